// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) round-robin read arbiter onto a single memory port.
// One transaction in flight; a timeout turns a silent memory into an error response.
module mem_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        i_ifu_arvalid,
  output logic        o_ifu_arready,
  input  logic [31:0] i_ifu_araddr,
  input  logic [1:0]  i_ifu_arsize,
  output logic        o_ifu_rvalid,
  input  logic        i_ifu_rready,
  output logic [31:0] o_ifu_rdata,
  output logic        o_ifu_rresp,
  input  logic        i_lsu_arvalid,
  output logic        o_lsu_arready,
  input  logic [31:0] i_lsu_araddr,
  input  logic [1:0]  i_lsu_arsize,
  output logic        o_lsu_rvalid,
  input  logic        i_lsu_rready,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_rresp,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_raddr,
  output logic [7:0]  o_mem_wmask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic        r_last;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_rresp;
  logic [31:0] r_raddr;
  logic [7:0]  r_wmask;

  logic        w_idle;
  logic        w_gnt_ifu;
  logic        w_gnt_lsu;
  logic        w_grant;
  logic        w_timeout;
  logic        w_rready;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [7:0]  w_mask;

  // r_last: 0 = IFU, 1 = LSU; on a tie the other requester wins
  assign w_idle    = (r_state == S_IDLE);
  assign w_gnt_ifu = w_idle && i_ifu_arvalid
                     && (!i_lsu_arvalid || r_last);
  assign w_gnt_lsu = w_idle && i_lsu_arvalid && !w_gnt_ifu;
  assign w_grant   = w_gnt_ifu || w_gnt_lsu;
  assign w_addr    = w_gnt_lsu ? i_lsu_araddr : i_ifu_araddr;
  assign w_size    = w_gnt_lsu ? i_lsu_arsize : i_ifu_arsize;
  assign w_timeout = (r_cnt == CW'(TIMEOUT));
  assign w_rready  = r_owner ? i_lsu_rready : i_ifu_rready;

  always_comb begin
    w_mask = 8'h04;
    unique case (w_size)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h02;
      default: w_mask = 8'h04;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_mem_rvalid || w_timeout) w_next = S_RESP;
      S_RESP:  if (w_rready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ifu_arready = 1'b0;
    o_lsu_arready = 1'b0;
    o_ifu_rvalid  = 1'b0;
    o_lsu_rvalid  = 1'b0;
    o_mem_ren     = 1'b0;
    if (ARESETn) begin
      o_ifu_arready = w_gnt_ifu;
      o_lsu_arready = w_gnt_lsu;
      o_mem_ren     = (r_state == S_ISSUE);
      o_ifu_rvalid  = (r_state == S_RESP) && !r_owner;
      o_lsu_rvalid  = (r_state == S_RESP) && r_owner;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_rresp <= 1'b0;
      r_raddr <= '0;
      r_wmask <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_lsu;
        r_last  <= w_gnt_lsu;
        r_raddr <= w_addr;
        r_wmask <= w_mask;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      // a pulse landing exactly on the timeout cycle still wins
      if (r_state == S_WAIT) begin
        if (i_mem_rvalid) begin
          r_rdata <= i_mem_rdata;
          r_rresp <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= ERR_DATA;
          r_rresp <= 1'b1;
        end
      end
    end
  end

  assign o_mem_raddr = r_raddr;
  assign o_mem_wmask = r_wmask;
  assign o_ifu_rdata = r_rdata;
  assign o_ifu_rresp = r_rresp;
  assign o_lsu_rdata = r_rdata;
  assign o_lsu_rresp = r_rresp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: IFU/LSU traffic,
// memory delays up to and past the timeout, plus reset-in-WAIT.
module tb_mem_arbiter;

  localparam int          TO    = 16;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
  localparam int          NEVER = 1000;
  localparam int          NTX   = 30;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    int          d;
    int          gcyc;
  } tx_t;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [1:0]       arvalid;
  logic [1:0]       arready;
  logic [1:0][31:0] araddr;
  logic [1:0][1:0]  arsize;
  logic [1:0]       rvalid;
  logic [1:0]       rready;
  logic [1:0][31:0] rdata;
  logic [1:0]       rresp;
  logic             mem_ren;
  logic [31:0]      mem_raddr;
  logic [7:0]       mem_wmask;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  mem_arbiter dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .i_ifu_arvalid (arvalid[0]),
    .o_ifu_arready (arready[0]),
    .i_ifu_araddr  (araddr[0]),
    .i_ifu_arsize  (arsize[0]),
    .o_ifu_rvalid  (rvalid[0]),
    .i_ifu_rready  (rready[0]),
    .o_ifu_rdata   (rdata[0]),
    .o_ifu_rresp   (rresp[0]),
    .i_lsu_arvalid (arvalid[1]),
    .o_lsu_arready (arready[1]),
    .i_lsu_araddr  (araddr[1]),
    .i_lsu_arsize  (arsize[1]),
    .o_lsu_rvalid  (rvalid[1]),
    .i_lsu_rready  (rready[1]),
    .o_lsu_rdata   (rdata[1]),
    .o_lsu_rresp   (rresp[1]),
    .o_mem_ren     (mem_ren),
    .o_mem_raddr   (mem_raddr),
    .o_mem_wmask   (mem_wmask),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  tx_t   expq [2][$];
  tx_t   memq [$];
  tx_t   cur [2];
  bit    want [2];
  int    left [2];
  int    mcnt = 0;
  logic [31:0] mdata;
  bit    busy;
  int    mlast;
  int    mowner;
  bit    seen [2];
  int    win;
  tx_t   mt;
  tx_t   rt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [7:0] maskf(input logic [1:0] s);
    int w;
    w = (s == 2'd3) ? 2 : int'(s);
    return 8'(1 << w);
  endfunction

  function automatic int pick_delay();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0, 1, 2: return 1;
      3:       return 2;
      4:       return 5;
      5:       return TO + 1;
      6:       return TO + 2;
      default: return NEVER;
    endcase
  endfunction

  // memory answers in time iff its pulse lands within TO+1 cycles of ren
  function automatic bit late(input int d);
    return d > TO + 1;
  endfunction

  function automatic int lat(input int d);
    return 2 + (late(d) ? TO + 1 : d);
  endfunction

  task automatic step();
    @(negedge ACLK);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!want[i] && left[i] > 0 && $urandom_range(0, 2) != 0) begin
        cur[i].addr = $urandom;
        cur[i].size = 2'($urandom);
        cur[i].d    = pick_delay();
        want[i]     = 1'b1;
      end
      arvalid[i] = want[i];
      araddr[i]  = want[i] ? cur[i].addr : $urandom;
      arsize[i]  = want[i] ? cur[i].size : 2'($urandom);
      rready[i]  = ($urandom_range(0, 3) != 0);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (arvalid[i] && arready[i]) begin
        cur[i].gcyc = cyc;
        expq[i].push_back(cur[i]);
        memq.push_back(cur[i]);
        want[i] = 1'b0;
        left[i]--;
      end
    end
    if (mem_ren) begin
      if (memq.size() == 0) begin
        chk("ren_without_grant", 32'(mem_ren), 32'd0);
      end else begin
        rt = memq.pop_front();
        chk("mem_raddr", mem_raddr, rt.addr);
        chk("mem_wmask", 32'(mem_wmask), 32'(maskf(rt.size)));
        chk("ren_cycle", 32'(cyc), 32'(rt.gcyc + 1));
        if (rt.d != NEVER) begin
          mcnt  = rt.d;
          mdata = memf(rt.addr);
        end
      end
    end
  endtask

  // monitor: arbitration model and response scoreboard
  always @(negedge ACLK) begin
    #2;
    if (mon_en) begin
      win = -1;
      if (!busy && arvalid != 2'b00) begin
        if (arvalid == 2'b11) win = 1 - mlast;
        else                  win = arvalid[1] ? 1 : 0;
      end
      chk("ifu_arready", 32'(arready[0]), 32'(win == 0));
      chk("lsu_arready", 32'(arready[1]), 32'(win == 1));
      if (win >= 0) begin
        busy   = 1'b1;
        mlast  = win;
        mowner = win;
      end
      for (int i = 0; i < 2; i++) begin
        if (rvalid[i]) begin
          chk("rvalid_owner", 32'(busy && mowner == i), 32'd1);
          if (expq[i].size() == 0) begin
            chk("rvalid_no_txn", 32'(rvalid[i]), 32'd0);
          end else begin
            mt = expq[i][0];
            chk("rdata", rdata[i], late(mt.d) ? ERR : memf(mt.addr));
            chk("rresp", 32'(rresp[i]), 32'(late(mt.d)));
            if (!seen[i]) begin
              chk("latency", 32'(cyc - mt.gcyc), 32'(lat(mt.d)));
              seen[i] = 1'b1;
            end
            if (rready[i]) begin
              void'(expq[i].pop_front());
              seen[i] = 1'b0;
              busy    = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
    chk({tag, "_mem_raddr"}, mem_raddr, 32'd0);
    chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    chk({tag, "_rdata"}, rdata[0], 32'd0);
    chk({tag, "_rresp"}, 32'(rresp), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bit done;
    arvalid    = 2'b11;
    araddr     = '0;
    arsize     = '0;
    rready     = 2'b11;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    ARESETn    = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    chk_reset_outputs("reset");

    @(negedge ACLK);
    arvalid = 2'b00;
    ARESETn = 1'b1;
    busy    = 1'b0;
    mlast   = 1;
    mowner  = 0;
    seen    = '{1'b0, 1'b0};
    want    = '{1'b0, 1'b0};
    left    = '{NTX, NTX};
    mon_en  = 1'b1;
    guard   = 0;
    done    = 1'b0;
    while (!done && guard < 20000) begin
      step();
      guard++;
      done = left[0] == 0 && left[1] == 0 && !busy
             && expq[0].size() == 0 && expq[1].size() == 0;
    end
    chk("traffic_drained", 32'(done), 32'd1);

    // reset while waiting on a silent memory
    @(negedge ACLK);
    mon_en     = 1'b0;
    mem_rvalid = 1'b0;
    rready     = 2'b11;
    arvalid    = 2'b01;
    araddr[0]  = 32'h8000_0004;
    arsize[0]  = 2'd2;
    #1;
    chk("dir_ifu_grant", 32'(arready), 32'b01);
    @(negedge ACLK);
    arvalid = 2'b00;
    #1;
    chk("dir_ren", 32'(mem_ren), 32'd1);
    chk("dir_raddr", mem_raddr, 32'h8000_0004);
    chk("dir_wmask", 32'(mem_wmask), 32'h04);
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    #1;
    chk_reset_outputs("midreset");
    ARESETn = 1'b1;
    @(negedge ACLK);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge ACLK);
    mem_rvalid = 1'b0;
    repeat (TO + 4) begin
      @(negedge ACLK);
      #1;
      chk("stray_rvalid", 32'(rvalid), 32'd0);
    end

    // first tie after reset goes to IFU
    @(negedge ACLK);
    arvalid   = 2'b11;
    araddr[1] = 32'h8000_0003;
    arsize[1] = 2'd0;
    #1;
    chk("tie_after_reset", 32'(arready), 32'b01);
    @(negedge ACLK);
    arvalid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
